// File: rtl/intan_acq_pkg.sv
// Shared types and constants for the Intan SPI acquisition front end:
// FSM state encoding, CONVERT command layout and header magic.
package intan_acq_pkg;

    // ST_HDR is only reachable when INTAN_ACQ_TIMESTAMP_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD
    } acq_state_e;

    localparam int unsigned CMD_W      = 16;
    localparam logic [1:0]  OP_CONVERT = 2'b00;
    localparam logic [7:0]  HDR_MAGIC  = 8'hA5;

    // CONVERT command for one channel: opcode, channel index, zero pad.
    function automatic logic [CMD_W-1:0] convert_cmd(input logic [5:0] ch);
        return {OP_CONVERT, ch, 8'h00};
    endfunction

    // Frame header word: magic byte followed by the 24-bit frame count.
    function automatic logic [31:0] make_header(input logic [23:0] frame);
        return {HDR_MAGIC, frame};
    endfunction

endpackage

// File: rtl/miso_sync.sv
// Two-flop synchronizer for one asynchronous MISO line into bus_clk.
module miso_sync (
    input  logic bus_clk,
    input  logic bus_rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input; first flop may go metastable.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the old
            // values on the same edge; blocking here would collapse the chain.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/intan_spi_acq.sv
// Intan headstage acquisition: sweeps CONVERT commands over NUM_CH channels on
// the SPI port and packs the two MISO result streams into 32-bit FIFO words.
// Optional feature macro: INTAN_ACQ_TIMESTAMP_EN adds a per-frame header word
// {8'hA5, frame_count[23:0]} emitted from a one-cycle HDR state.
module intan_spi_acq
    import intan_acq_pkg::*;
#(
    parameter int unsigned NUM_CH  = 32,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_HIGH = 4
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        enable,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso1,
    input  logic        spi_miso2,
    output logic [31:0] out_data,
    output logic        out_wren,
    input  logic        out_full,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned     CNT_W     = 16;
    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CS_HIGH - 1);
    localparam logic [5:0]       CH_LAST   = 6'(NUM_CH - 1);

`ifdef INTAN_ACQ_TIMESTAMP_EN
    localparam acq_state_e ST_START = ST_HDR;
`else
    localparam acq_state_e ST_START = ST_CS_SETUP;
`endif

    acq_state_e       state, state_d;
    logic [CNT_W-1:0] cyc_cnt, cyc_d;
    logic [3:0]       bit_cnt, bit_d;
    logic             sclk_hi, sclk_hi_d;
    logic [5:0]       ch_cnt, ch_d;
    logic [23:0]      frame_cnt, frame_d;
    logic             enable_q;

    logic             miso1_s, miso2_s;
    logic [15:0]      miso1_word, miso2_word;
    logic             sample_en;

    logic [CMD_W-1:0] cmd_d;
    logic             cs_n_d, sclk_d, mosi_d;
    logic             push_hdr, push_word, push;
    logic [31:0]      push_data;
    logic             overflow_clr;

    miso_sync u_sync1 (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .d         (spi_miso1),
        .q         (miso1_s)
    );

    miso_sync u_sync2 (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .d         (spi_miso2),
        .q         (miso2_s)
    );

    // State register and sequencing counters.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state     <= ST_IDLE;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            sclk_hi   <= 1'b0;
            ch_cnt    <= '0;
            frame_cnt <= '0;
            enable_q  <= 1'b0;
        end else begin
            state     <= state_d;
            cyc_cnt   <= cyc_d;
            bit_cnt   <= bit_d;
            sclk_hi   <= sclk_hi_d;
            ch_cnt    <= ch_d;
            frame_cnt <= frame_d;
            enable_q  <= enable;
        end
    end

    // Next-state logic: CS setup, 16 SCLK periods, CS hold, channel/frame stepping.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d   = state;
        cyc_d     = cyc_cnt + CNT_W'(1);
        bit_d     = bit_cnt;
        sclk_hi_d = sclk_hi;
        ch_d      = ch_cnt;
        frame_d   = frame_cnt;
        case (state)
            ST_IDLE: begin
                cyc_d = '0;
                if (enable) state_d = ST_START;
            end
            ST_HDR: begin
                cyc_d   = '0;
                state_d = ST_CS_SETUP;
            end
            ST_CS_SETUP: begin
                if (cyc_cnt == CLK_LAST) begin
                    cyc_d     = '0;
                    bit_d     = '0;
                    sclk_hi_d = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cyc_cnt == CLK_LAST) begin
                    cyc_d = '0;
                    if (sclk_hi) begin
                        sclk_hi_d = 1'b0;
                    end else if (bit_cnt == 4'd15) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        bit_d     = bit_cnt + 4'd1;
                        sclk_hi_d = 1'b1;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (cyc_cnt == HOLD_LAST) begin
                    cyc_d = '0;
                    if (ch_cnt == CH_LAST) begin
                        // Frame boundary: a dropped enable only takes effect here.
                        ch_d    = '0;
                        frame_d = frame_cnt + 24'd1;
                        state_d = enable ? ST_START : ST_IDLE;
                    end else begin
                        ch_d    = ch_cnt + 6'd1;
                        state_d = ST_CS_SETUP;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin and push values derived from the next state, so the registered
    // outputs line up with the state they belong to.
    always_comb begin
        cmd_d  = convert_cmd(ch_d);
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        case (state_d)
            ST_CS_SETUP: begin
                cs_n_d = 1'b0;
                mosi_d = cmd_d[CMD_W-1];
            end
            ST_SHIFT: begin
                cs_n_d = 1'b0;
                sclk_d = sclk_hi_d;
                // MOSI moves to the next bit on each falling edge.
                if (sclk_hi_d) mosi_d = cmd_d[4'd15 - bit_d];
                else if (bit_d != 4'd15) mosi_d = cmd_d[4'd14 - bit_d];
            end
            default: ;
        endcase

`ifdef INTAN_ACQ_TIMESTAMP_EN
        push_hdr = (state_d == ST_HDR);
`else
        push_hdr = 1'b0;
`endif
        push_word    = (state == ST_SHIFT) && (state_d == ST_CS_HOLD);
        push         = push_hdr || push_word;
        push_data    = push_hdr ? make_header(frame_d) : {miso2_word, miso1_word};
        overflow_clr = (state == ST_IDLE) && enable && !enable_q;
        sample_en    = (state == ST_SHIFT) && !sclk_hi && (cyc_cnt == '0);
    end

    // MISO capture: shift in the synchronized bit on the cycle SCLK goes low.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            // NOTE: the capture registers are reset as well, so a word cut
            // short by reset can never leak stale bits into a later push.
            miso1_word <= '0;
            miso2_word <= '0;
        end else if (sample_en) begin
            miso1_word <= {miso1_word[14:0], miso1_s};
            miso2_word <= {miso2_word[14:0], miso2_s};
        end
    end

    // Registered SPI pins, FIFO write side, busy and sticky overflow.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            spi_cs_n <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            out_data <= '0;
            out_wren <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            spi_cs_n <= cs_n_d;
            spi_sclk <= sclk_d;
            spi_mosi <= mosi_d;
            busy     <= (state_d != ST_IDLE);
            // out_full is sampled on the edge that would raise out_wren; a
            // full FIFO drops the word without stalling the SPI sequence.
            out_wren <= push && !out_full;
            if (push && !out_full) out_data <= push_data;
            if (overflow_clr) overflow <= 1'b0;
            else if (push && out_full) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_intan_spi_acq.sv
// Scoreboard bench for intan_spi_acq (NUM_CH=4, CLK_DIV=2, CS_HIGH=4).
// Header expectations follow INTAN_ACQ_TIMESTAMP_EN when it is defined.
module tb_intan_spi_acq;

    localparam int NUM_CH  = 4;
    localparam int CLK_DIV = 2;
    localparam int CS_HIGH = 4;
`ifdef INTAN_ACQ_TIMESTAMP_EN
    localparam int TS = 1;
`else
    localparam int TS = 0;
`endif
    localparam int PF = NUM_CH + TS;      // pushes per full frame
    localparam logic [31:0] DATA_WORD = 32'hABCD1234;

    logic        bus_clk;
    logic        bus_rst_n;
    logic        enable;
    logic        spi_cs_n, spi_sclk, spi_mosi;
    logic        spi_miso1 = 1'b0;
    logic        spi_miso2 = 1'b0;
    logic [31:0] out_data;
    logic        out_wren;
    logic        out_full;
    logic        busy, overflow;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          push_count = 0;
    int          push_cyc[$];
    logic [31:0] exp_q[$];

    intan_spi_acq #(
        .NUM_CH  (NUM_CH),
        .CLK_DIV (CLK_DIV),
        .CS_HIGH (CS_HIGH)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .enable    (enable),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso1 (spi_miso1),
        .spi_miso2 (spi_miso2),
        .out_data  (out_data),
        .out_wren  (out_wren),
        .out_full  (out_full),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    always @(posedge bus_clk) cyc++;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    task automatic timeout(input string name, input int budget);
        n_checks++;
        $display("FAIL %s: no response within %0d cycles", name, budget);
    endtask

    task automatic wait_pushes(input int target, input int budget, input string name);
        int n = 0;
        while (push_count < target && n < budget) begin
            @(negedge bus_clk);
            n++;
        end
        if (push_count < target) timeout(name, budget);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge bus_clk);
            n++;
        end
        if (busy !== 1'b0) timeout(name, budget);
    endtask

    // Queue the words one frame should produce; skip < 0 drops nothing.
    task automatic push_frame(input int frame, input int n_data, input int skip);
        if (TS == 1) exp_q.push_back({8'hA5, 24'(frame)});
        for (int i = 0; i < n_data; i++)
            if (i != skip) exp_q.push_back(DATA_WORD);
    endtask

    // Monitor: every FIFO write is popped from the scoreboard and compared.
    always @(negedge bus_clk) begin
        logic [31:0] exp_word;
        if (bus_rst_n && out_wren) begin
            push_cyc.push_back(cyc);
            push_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL push_data: got %h, expected no write", out_data);
            end else begin
                exp_word = exp_q.pop_front();
                check("push_data", out_data, exp_word);
            end
        end
    end

    // Headstage model: captures MOSI on SCLK rise, returns 1234/ABCD on MISO,
    // and checks each completed command against the channel sweep.
    logic [15:0] pat1 = 16'h1234;
    logic [15:0] pat2 = 16'hABCD;
    logic [15:0] mosi_word = '0;
    logic [15:0] exp_cmd;
    logic        sclk_prev = 1'b0;
    logic        cs_prev   = 1'b1;
    int          bit_k     = 0;
    int          model_ch  = 0;

    always @(negedge bus_clk) begin
        if (!bus_rst_n) begin
            bit_k     = 0;
            model_ch  = 0;
            mosi_word = '0;
            spi_miso1 = 1'b0;
            spi_miso2 = 1'b0;
        end else begin
            if (!spi_cs_n && spi_sclk && !sclk_prev) begin
                mosi_word = {mosi_word[14:0], spi_mosi};
                if (bit_k < 16) begin
                    spi_miso1 = pat1[15 - bit_k];
                    spi_miso2 = pat2[15 - bit_k];
                end
                bit_k++;
            end
            if (spi_cs_n && !cs_prev) begin
                exp_cmd = {2'b00, 6'(model_ch), 8'h00};
                check("mosi_cmd", {16'(bit_k), mosi_word}, {16'd16, exp_cmd});
                bit_k     = 0;
                mosi_word = '0;
                model_ch  = (model_ch + 1) % NUM_CH;
            end
        end
        sclk_prev = spi_sclk;
        cs_prev   = spi_cs_n;
    end

    initial begin
        repeat (30000) @(posedge bus_clk);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        bus_rst_n = 1'b0;
        enable    = 1'b0;
        out_full  = 1'b0;
        repeat (3) @(negedge bus_clk);
        check("rst_cs_n",     spi_cs_n, 1);
        check("rst_sclk",     spi_sclk, 0);
        check("rst_mosi",     spi_mosi, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_wren", out_wren, 0);
        check("rst_busy",     busy,     0);
        check("rst_overflow", overflow, 0);
        bus_rst_n = 1'b1;
        repeat (2) @(negedge bus_clk);
        check("idle_busy", busy, 0);

        // Frames 0..3 run back to back; frame 2 loses its third push.
        push_frame(0, 4, -1);
        push_frame(1, 4, -1);
        push_frame(2, 4, 2 - TS);
        push_frame(3, 4, -1);
        enable = 1'b1;
        #1 check("busy_before_sample", busy, 0);
        @(negedge bus_clk);
        check("busy_rise", busy, 1);
        check("first_cycle_cs_n", spi_cs_n, 32'(TS));
        check("first_cycle_wren", out_wren, 32'(TS));

        wait_pushes(2 * PF, 1000, "two_frames");
        if (push_cyc.size() >= 2 * PF) begin
            check("word_period",  push_cyc[TS + 1] - push_cyc[TS], 70);
            check("frame_period", push_cyc[PF + TS] - push_cyc[TS], 280 + TS);
            check("frame_gap",    push_cyc[PF + TS] - push_cyc[PF - 1], 70 + TS);
        end
        check("overflow_clear_run", overflow, 0);

        wait_pushes(2 * PF + 2, 400, "frame2_second_push");
        repeat (30) @(negedge bus_clk);
        out_full = 1'b1;
        repeat (60) @(negedge bus_clk);
        out_full = 1'b0;
        check("drop_count",   push_count, 2 * PF + 2);
        check("overflow_set", overflow, 1);

        // Drop enable while channel 1 of frame 3 is shifting.
        wait_pushes(3 * PF + TS, 600, "frame3_ch0");
        repeat (20) @(negedge bus_clk);
        enable = 1'b0;
        wait_pushes(4 * PF - 1, 400, "frame3_finish");
        wait_idle(50, "frame3_idle");
        check("stop_busy",     busy,     0);
        check("stop_cs_n",     spi_cs_n, 1);
        check("stop_sclk",     spi_sclk, 0);
        check("overflow_held", overflow, 1);
        repeat (100) @(negedge bus_clk);
        check("no_push_idle", push_count, 4 * PF - 1);

        // Re-enable clears overflow; then reset lands in the middle of SHIFT.
        push_frame(4, 1, -1);
        enable = 1'b1;
        repeat (2) @(negedge bus_clk);
        check("overflow_cleared", overflow, 0);
        check("rerun_busy",       busy,     1);
        wait_pushes(4 * PF + TS, 200, "frame4_ch0");
        base = 0;
        while (spi_sclk !== 1'b1 && base < 100) begin
            @(negedge bus_clk);
            base++;
        end
        check("sclk_high_before_reset", spi_sclk, 1);
        @(posedge bus_clk);
        #1;
        bus_rst_n = 1'b0;
        enable    = 1'b0;
        #1;
        check("midrst_cs_n",     spi_cs_n, 1);
        check("midrst_sclk",     spi_sclk, 0);
        check("midrst_mosi",     spi_mosi, 0);
        check("midrst_out_wren", out_wren, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy",     busy,     0);
        repeat (3) @(negedge bus_clk);
        bus_rst_n = 1'b1;
        repeat (100) @(negedge bus_clk);
        check("no_push_after_reset", push_count, 4 * PF + TS);
        check("post_reset_cs_n",     spi_cs_n, 1);

        // One more frame after reset: frame counter restarts at 0.
        base = push_count;
        push_frame(0, 4, -1);
        enable = 1'b1;
        repeat (3) @(negedge bus_clk);
        enable = 1'b0;
        wait_pushes(base + PF, 400, "final_frame");
        wait_idle(50, "final_idle");
        check("final_busy",     busy,     0);
        check("final_overflow", overflow, 0);
        check("sb_drained",     exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
